// File: rtl/mcb_cmd_pkg.sv
// rtl/mcb_cmd_pkg.sv - command/CKE enums, pin encodings and strobe priority for mcb_cmd_sig_pipe
package mcb_cmd_pkg;

   localparam int NUM_STROBES = 10;
   localparam int CMD_W       = 4;

   // Enum order matches the strobe priority, highest first.
   typedef enum logic [CMD_W-1:0] {
      CMD_NOP  = 4'd0,
      CMD_LMR  = 4'd1,
      CMD_PREA = 4'd2,
      CMD_IREF = 4'd3,
      CMD_CREF = 4'd4,
      CMD_PRE  = 4'd5,
      CMD_ACT  = 4'd6,
      CMD_WRA  = 4'd7,
      CMD_WR   = 4'd8,
      CMD_RDA  = 4'd9,
      CMD_RD   = 4'd10
   } cmd_t;

   typedef enum logic [2:0] {
      CKE_INIT   = 3'd0,
      CKE_ACTIVE = 3'd1,
      CKE_PDN    = 3'd2,
      CKE_SREF   = 3'd3,
      CKE_EXIT   = 3'd4
   } cke_state_t;

   // Strobe vector bit i requests command i+1; the lowest set bit wins.
   function automatic cmd_t prio_pick(input logic [NUM_STROBES-1:0] s);
      cmd_t c;
      c = CMD_NOP;
      for (int i = NUM_STROBES - 1; i >= 0; i--) begin
         if (s[i]) c = cmd_t'(CMD_W'(i + 1));
      end
      return c;
   endfunction

   // {ras_n, cas_n, we_n}
   function automatic logic [2:0] cmd_rcw(input cmd_t c);
      logic [2:0] r;
      case (c)
         CMD_LMR:            r = 3'b000;
         CMD_PREA, CMD_PRE:  r = 3'b010;
         CMD_IREF, CMD_CREF: r = 3'b001;
         CMD_ACT:            r = 3'b011;
         CMD_WRA, CMD_WR:    r = 3'b100;
         CMD_RDA, CMD_RD:    r = 3'b101;
         default:            r = 3'b111;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mcb_cke_fsm.sv
// rtl/mcb_cke_fsm.sv - CKE power-down/self-refresh state machine with exit counter
module mcb_cke_fsm
   import mcb_cmd_pkg::*;
#(
   parameter int XP_CK  = 2,
   parameter int XSR_CK = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclr_n,
   input  logic strobe_any,
   input  logic pd_req,
   input  logic sr_req,
   output logic cke_rdy,
   output logic cke_cmd,
   output logic sref_entry
);

   localparam int XMAX = (XP_CK > XSR_CK) ? XP_CK : XSR_CK;
   localparam int CW   = (XMAX > 0) ? $clog2(XMAX + 1) : 1;

   cke_state_t     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CKE_INIT;
         cnt_q   <= '0;
      end else if (!sclr_n) begin
         state_q <= CKE_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sref_entry = 1'b0;
      case (state_q)
         CKE_INIT: state_d = CKE_ACTIVE;
         CKE_ACTIVE: begin
            if (!strobe_any) begin
               if (sr_req) begin
                  state_d    = CKE_SREF;
                  sref_entry = 1'b1;
               end else if (pd_req) begin
                  state_d = CKE_PDN;
               end
            end
         end
         CKE_PDN: begin
            if (!pd_req) begin
               state_d = CKE_EXIT;
               cnt_d   = CW'(XP_CK);
            end
         end
         CKE_SREF: begin
            if (!sr_req) begin
               state_d = CKE_EXIT;
               cnt_d   = CW'(XSR_CK);
            end
         end
         CKE_EXIT: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CW'(1)) state_d = CKE_ACTIVE;
         end
         default: state_d = CKE_INIT;
      endcase
   end

   // CKE follows the state being entered so it lines up with the command issued this cycle.
   assign cke_cmd = (state_d == CKE_ACTIVE) || (state_d == CKE_EXIT);
   assign cke_rdy = (state_q == CKE_ACTIVE);

endmodule

// File: rtl/mcb_cmd_sig_pipe.sv
// rtl/mcb_cmd_sig_pipe.sv - MCB command decode and SDRAM pin pipeline; MCB_CMD_CHK_EN enables cmd_err
module mcb_cmd_sig_pipe
   import mcb_cmd_pkg::*;
#(
   parameter int             B_W    = 2,
   parameter int             R_W    = 13,
   parameter int             C_W    = 9,
   parameter int             A_W    = 13,
   parameter int             RK_W   = 1,
   parameter int             AP_BIT = 10,
   parameter int             PIPE   = 1,
   parameter logic [A_W-1:0] MR_VAL = 'h0033,
   parameter int             XP_CK  = 2,
   parameter int             XSR_CK = 8,
   localparam int            RANKS  = 2 ** RK_W
) (
   input  logic             mcb_clk,
   input  logic             mcb_rst_n,
   input  logic             mcb_sclr_n,
   input  logic             mcb_bb,
   input  logic [RK_W-1:0]  mcb_rk,
   input  logic [B_W-1:0]   mcb_ba,
   input  logic [R_W-1:0]   mcb_ra,
   input  logic [C_W-1:0]   mcb_ca,
   input  logic             i_prea,
   input  logic             i_ref,
   input  logic             i_lmr,
   input  logic             c_ref,
   input  logic             c_pre,
   input  logic             c_act,
   input  logic             c_rda,
   input  logic             c_rd,
   input  logic             c_wra,
   input  logic             c_wr,
   input  logic             pd_req,
   input  logic             sr_req,
   output logic             cke_rdy,
   output logic [RANKS-1:0] sdr_cke,
   output logic [RANKS-1:0] sdr_cs_n,
   output logic             sdr_ras_n,
   output logic             sdr_cas_n,
   output logic             sdr_we_n,
   output logic [B_W-1:0]   sdr_ba,
   output logic [A_W-1:0]   sdr_addr,
   output logic             cmd_err
);

   localparam int PW = 2 * RANKS + 3 + B_W + A_W;
   localparam logic [PW-1:0] RST_WORD =
      {{RANKS{1'b0}}, {RANKS{1'b1}}, 3'b111, {B_W{1'b0}}, {A_W{1'b0}}};

   logic [RK_W-1:0]        rk_q;
   logic [B_W-1:0]         ba_q;
   logic [R_W-1:0]         ra_q;
   logic [C_W-1:0]         ca_q;
   logic [NUM_STROBES-1:0] strobes;
   logic                   strobe_any;
   logic                   cke_cmd;
   logic                   sref_entry;
   cmd_t                   cmd;
   logic [RANKS-1:0]       cs_n_d;
   logic [RANKS-1:0]       rank_cs_n;
   logic [B_W-1:0]         ba_d;
   logic [A_W-1:0]         addr_d;
   logic [PW-1:0]          pipe_q [PIPE];

   assign strobes    = {c_rd, c_rda, c_wr, c_wra, c_act, c_pre, c_ref, i_ref, i_prea, i_lmr};
   assign strobe_any = |strobes;

   always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
      if (!mcb_rst_n) begin
         rk_q <= '0;
         ba_q <= '0;
         ra_q <= '0;
         ca_q <= '0;
      end else if (!mcb_sclr_n) begin
         rk_q <= '0;
         ba_q <= '0;
         ra_q <= '0;
         ca_q <= '0;
      end else if (mcb_bb) begin
         rk_q <= mcb_rk;
         ba_q <= mcb_ba;
         ra_q <= mcb_ra;
         ca_q <= mcb_ca;
      end
   end

   mcb_cke_fsm #(
      .XP_CK  (XP_CK),
      .XSR_CK (XSR_CK)
   ) u_cke_fsm (
      .clk        (mcb_clk),
      .rst_n      (mcb_rst_n),
      .sclr_n     (mcb_sclr_n),
      .strobe_any (strobe_any),
      .pd_req     (pd_req),
      .sr_req     (sr_req),
      .cke_rdy    (cke_rdy),
      .cke_cmd    (cke_cmd),
      .sref_entry (sref_entry)
   );

   // Self-refresh entry only happens with no strobe present, so it never displaces a command.
   assign cmd       = sref_entry ? CMD_IREF : (cke_rdy ? prio_pick(strobes) : CMD_NOP);
   assign rank_cs_n = ~(RANKS'(1) << rk_q);

   always_comb begin
      cs_n_d = '1;
      ba_d   = '0;
      addr_d = '0;
      case (cmd)
         CMD_LMR: begin
            cs_n_d = '0;
            addr_d = MR_VAL;
         end
         CMD_PREA: begin
            cs_n_d         = '0;
            addr_d[AP_BIT] = 1'b1;
         end
         CMD_IREF: cs_n_d = '0;
         CMD_CREF: cs_n_d = rank_cs_n;
         CMD_PRE: begin
            cs_n_d = rank_cs_n;
            ba_d   = ba_q;
         end
         CMD_ACT: begin
            cs_n_d = rank_cs_n;
            ba_d   = ba_q;
            addr_d = A_W'(ra_q);
         end
         CMD_WRA, CMD_WR, CMD_RDA, CMD_RD: begin
            cs_n_d = rank_cs_n;
            ba_d   = ba_q;
            addr_d = A_W'(ca_q);
            if (cmd == CMD_WRA || cmd == CMD_RDA) addr_d[AP_BIT] = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
      if (!mcb_rst_n) begin
         for (int k = 0; k < PIPE; k++) pipe_q[k] <= RST_WORD;
      end else if (!mcb_sclr_n) begin
         for (int k = 0; k < PIPE; k++) pipe_q[k] <= RST_WORD;
      end else begin
         pipe_q[0] <= {{RANKS{cke_cmd}}, cs_n_d, cmd_rcw(cmd), ba_d, addr_d};
         for (int k = 1; k < PIPE; k++) pipe_q[k] <= pipe_q[k-1];
      end
   end

   assign {sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr} = pipe_q[PIPE-1];

`ifdef MCB_CMD_CHK_EN
   logic err_q;
   logic multi;

   assign multi = (strobes & (strobes - 1'b1)) != '0;

   always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
      if (!mcb_rst_n)                           err_q <= 1'b0;
      else if (!mcb_sclr_n)                     err_q <= 1'b0;
      else if (multi || (strobe_any && !cke_rdy)) err_q <= 1'b1;
   end

   assign cmd_err = err_q;
`else
   assign cmd_err = 1'b0;
`endif

endmodule
